// File: rtl/cla64_sequencer.sv
// rtl/cla64_sequencer.sv - two-requester round-robin sequencer for the shared 64-bit CLA adder
module cla64_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic        req1_sub,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_sum,
    output logic        rsp_cout,
    output logic [63:0] add_a,
    output logic [63:0] add_b,
    input  logic [63:0] add_s,
    input  logic        add_cout,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    state_t      state_q, state_d;
    logic [63:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic        sub_q, sub_d, id_q, id_d, last_q, last_d;
    logic        c1_q, c1_d, cout_q, cout_d;
    logic        fire0, fire1;

    // A requester's ready looks only at the other side's valid, so no valid->ready loop exists.
    always_comb begin
        req0_ready = rst_n && (state_q == IDLE) && (!req1_valid || last_q);
        req1_ready = rst_n && (state_q == IDLE) && (!req0_valid || !last_q);
        fire0      = req0_valid && req0_ready;
        fire1      = req1_valid && req1_ready;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        id_d    = id_q;
        last_d  = last_q;
        res_d   = res_q;
        c1_d    = c1_q;
        cout_d  = cout_q;
        add_a   = 64'd0;
        add_b   = 64'd0;
        case (state_q)
            IDLE: begin
                if (fire0 || fire1) begin
                    a_d     = fire1 ? req1_a   : req0_a;
                    b_d     = fire1 ? req1_b   : req0_b;
                    sub_d   = fire1 ? req1_sub : req0_sub;
                    id_d    = fire1;
                    last_d  = fire1;
                    state_d = PASS1;
                end
            end
            PASS1: begin
                add_a   = a_q;
                add_b   = sub_q ? ~b_q : b_q;
                res_d   = add_s;
                c1_d    = add_cout;
                cout_d  = add_cout;
                state_d = sub_q ? PASS2 : RESP;
            end
            PASS2: begin
                // Second pass supplies the missing carry-in of the two's-complement subtract.
                add_a   = res_q;
                add_b   = 64'd1;
                res_d   = add_s;
                cout_d  = c1_q | add_cout;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 64'd0;
            b_q     <= 64'd0;
            sub_q   <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            res_q   <= 64'd0;
            c1_q    <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            id_q    <= id_d;
            last_q  <= last_d;
            res_q   <= res_d;
            c1_q    <= c1_d;
            cout_q  <= cout_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_sum   = res_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;
endmodule
